// File: rtl/tcb_pkg.sv
// tcb_pkg: shared TCB arbiter types and handshake defaults.
package tcb_pkg;

    typedef enum logic {ARB_FIXED, ARB_RR} tcb_arb_md_t;

    typedef enum logic [1:0] {IDLE, HOLD, LOCK} tcb_arb_st_t;

    typedef struct packed {
        int unsigned DLY;
    } tcb_hsk_cfg_t;

    localparam tcb_hsk_cfg_t TCB_HSK_DEF = '{DLY: 1};

endpackage

// File: rtl/tcb_lib_arb_pick.sv
// tcb_lib_arb_pick: combinational winner picker, rotated round-robin from a start index or fixed priority.
module tcb_lib_arb_pick
    import tcb_pkg::*;
#(
    parameter tcb_arb_md_t MD  = ARB_RR,
    parameter int unsigned IFN = 3,
    parameter int unsigned IFL = $clog2(IFN),
    parameter int unsigned PRI [IFN-1:0] = '{2, 1, 0}
)(
    input  logic [IFN-1:0] vld,
    input  logic [IFL-1:0] start,
    output logic           valid,
    output logic [IFL-1:0] idx
);

    always_comb begin
        int unsigned j;
        int unsigned best;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        best  = 0;
        if (MD == ARB_RR) begin
            for (int unsigned k = 0; k < IFN; k++) begin
                j = 32'(start) + k;
                j = (j >= IFN) ? j - IFN : j;
                if (!valid && vld[j]) begin
                    valid = 1'b1;
                    idx   = IFL'(j);
                end
            end
        end else begin
            // strict compare keeps the lowest index on equal priority
            for (int unsigned i = 0; i < IFN; i++) begin
                if (vld[i] && (!valid || PRI[i] < best)) begin
                    valid = 1'b1;
                    best  = PRI[i];
                    idx   = IFL'(i);
                end
            end
        end
    end

endmodule

// File: rtl/tcb_lib_arbiter_rr.sv
// tcb_lib_arbiter_rr: locking fixed/round-robin arbiter driving the TCB multiplexer select,
// with a delayed select for the response path.
module tcb_lib_arbiter_rr
    import tcb_pkg::*;
#(
    parameter tcb_arb_md_t MD  = ARB_RR,
    parameter int unsigned IFN = 3,
    parameter int unsigned IFL = $clog2(IFN),
    parameter int unsigned PRI [IFN-1:0] = '{2, 1, 0},
    parameter int unsigned DLY = TCB_HSK_DEF.DLY
)(
    input  logic           clk,
    input  logic           rst,
    input  logic [IFN-1:0] vld,
    input  logic [IFN-1:0] lck,
    input  logic           rdy,
    output logic [IFN-1:0] gnt,
    output logic [IFL-1:0] sel,
    output logic [IFL-1:0] rsp_sel
);

    tcb_arb_st_t    state, next;
    logic [IFL-1:0] sel_r, ptr, pw;
    logic [IFN-1:0] own;
    logic           pv, trn;

    tcb_lib_arb_pick #(.MD(MD), .IFN(IFN), .IFL(IFL), .PRI(PRI)) u_pick (
        .vld   (vld),
        .start (ptr),
        .valid (pv),
        .idx   (pw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel_r <= '0;
            ptr   <= '0;
        end else begin
            state <= next;
            sel_r <= sel;
            if (trn && !lck[sel])
                ptr <= (sel == IFL'(IFN - 1)) ? '0 : IFL'(sel + 1'b1);
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (pv) next = !rdy ? HOLD : lck[pw] ? LOCK : IDLE;
            HOLD:    next = !vld[sel_r] ? IDLE : !rdy ? HOLD : lck[sel_r] ? LOCK : IDLE;
            LOCK:    if (vld[sel_r]) next = !rdy ? HOLD : lck[sel_r] ? LOCK : IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        own = IFN'(1) << sel_r;
        gnt = rst ? '0 : (state == IDLE) ? (pv ? IFN'(1) << pw : '0) : (state == HOLD) ? own : own & vld;
        sel = rst ? '0 : (state == IDLE && pv) ? pw : sel_r;
        trn = |(gnt & vld) & rdy;
    end

    generate
        if (DLY == 0) begin : g_d0
            assign rsp_sel = sel;
        end else begin : g_dly
            logic [IFL-1:0] pipe [DLY];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned k = 0; k < DLY; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= trn ? sel : pipe[0];
                    for (int unsigned k = 1; k < DLY; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign rsp_sel = pipe[DLY-1];
        end
    endgenerate

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_vld: assert property (@(posedge clk) disable iff (rst) (gnt & ~vld) == '0);
    a_hold_vld: assert property (@(posedge clk) disable iff (rst) state == HOLD |-> vld[sel_r])
        else $error("vld dropped while stalled on manager %0d", sel_r);
    a_hold_sel: assert property (@(posedge clk) disable iff (rst) state == HOLD |=> state != HOLD || $stable(sel));

endmodule
